// File: rtl/fir_stream_engine.sv
// ----------------------------------------------------------------------------
// fir_stream_engine
//   Job-based streaming FIR filter. A job is launched from IDLE with start_i,
//   which latches the sample count, tap coefficients and output shift. Each
//   accepted input sample shifts the delay line and produces one filtered,
//   shifted and saturated output sample one cycle later. When the last
//   output of the job has been delivered the engine reports done for one
//   cycle and returns to IDLE.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous flush of all state (beats start_i)
//   start_i, len_i         job start pulse and number of samples
//   coeff_i                N_TAPS packed coefficients, tap k at [k*COEFF_W +: COEFF_W]
//   shift_i                arithmetic right shift applied to the accumulator
//   a_data_i/a_valid_i/a_ready_o   input sample stream
//   b_data_o/b_valid_o/b_ready_i   output sample stream
//   b_strb_o               byte strobe for b_data_o, always all-ones
//   done_o, idle_o, ready_o        job status flags
//   cnt_o                  output samples delivered in the current job
// ----------------------------------------------------------------------------
module fir_stream_engine #(
   parameter int DATA_W  = 16,
   parameter int COEFF_W = 16,
   parameter int N_TAPS  = 4,
   parameter int CNT_W   = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,
   input  logic                      start_i,
   input  logic [CNT_W-1:0]          len_i,
   input  logic [N_TAPS*COEFF_W-1:0] coeff_i,
   input  logic [5:0]                shift_i,
   input  logic [DATA_W-1:0]         a_data_i,
   input  logic                      a_valid_i,
   output logic                      a_ready_o,
   output logic [DATA_W-1:0]         b_data_o,
   output logic                      b_valid_o,
   input  logic                      b_ready_i,
   output logic [DATA_W/8-1:0]       b_strb_o,
   output logic                      done_o,
   output logic                      idle_o,
   output logic                      ready_o,
   output logic [CNT_W-1:0]          cnt_o
);

   localparam int ACC_W = DATA_W + COEFF_W + $clog2(N_TAPS);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                    state_q;
   logic [CNT_W-1:0]          len_q;
   logic [CNT_W-1:0]          in_cnt_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [5:0]                shift_q;
   logic signed [COEFF_W-1:0] coef_q [N_TAPS];
   logic signed [DATA_W-1:0]  x_q    [N_TAPS];
   logic signed [DATA_W-1:0]  x_d    [N_TAPS];
   logic signed [ACC_W-1:0]   acc_d;
   logic signed [ACC_W-1:0]   shifted_d;
   logic signed [DATA_W-1:0]  y_d;
   logic signed [DATA_W-1:0]  b_data_q;
   logic                      b_valid_q;
   logic                      done_q;
   logic                      idle_q;
   logic                      ready_q;
   logic                      in_xfer;
   logic                      out_xfer;

   // Clamp a full-precision value into the signed DATA_W range.
   function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] max_v;
      logic signed [ACC_W-1:0] min_v;
      max_v = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
      min_v = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
      if (v > max_v) begin
         return max_v[DATA_W-1:0];
      end else if (v < min_v) begin
         return min_v[DATA_W-1:0];
      end
      return v[DATA_W-1:0];
   endfunction

   // A new input is accepted only when the output register is free or is
   // being emptied in the same cycle, which gives full throughput.
   assign a_ready_o = (state_q == RUN) && (!b_valid_q || b_ready_i);
   assign in_xfer   = a_valid_i && a_ready_o;
   assign out_xfer  = b_valid_q && b_ready_i;

   // Datapath: delay line as it will look after the shift, and the filter
   // sum computed over those new contents.
   always_comb begin
      logic signed [ACC_W-1:0] c_ext;
      logic signed [ACC_W-1:0] x_ext;
      c_ext = '0;
      x_ext = '0;
      x_d[0] = a_data_i;
      for (int k = 1; k < N_TAPS; k++) begin
         x_d[k] = x_q[k-1];
      end
      acc_d = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         c_ext = {{(ACC_W-COEFF_W){coef_q[k][COEFF_W-1]}}, coef_q[k]};
         x_ext = {{(ACC_W-DATA_W){x_d[k][DATA_W-1]}}, x_d[k]};
         acc_d = acc_d + c_ext * x_ext;
      end
      shifted_d = acc_d >>> shift_q;
      y_d       = saturate(shifted_d);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         len_q     <= '0;
         in_cnt_q  <= '0;
         cnt_q     <= '0;
         shift_q   <= '0;
         b_data_q  <= '0;
         b_valid_q <= 1'b0;
         done_q    <= 1'b0;
         idle_q    <= 1'b1;
         ready_q   <= 1'b0;
         for (int k = 0; k < N_TAPS; k++) begin
            coef_q[k] <= '0;
            x_q[k]    <= '0;
         end
      end else if (clear_i) begin
         // Flush everything; a pending output is simply dropped.
         state_q   <= IDLE;
         len_q     <= '0;
         in_cnt_q  <= '0;
         cnt_q     <= '0;
         shift_q   <= '0;
         b_data_q  <= '0;
         b_valid_q <= 1'b0;
         done_q    <= 1'b0;
         idle_q    <= 1'b1;
         ready_q   <= 1'b0;
         for (int k = 0; k < N_TAPS; k++) begin
            coef_q[k] <= '0;
            x_q[k]    <= '0;
         end
      end else begin
         ready_q <= (state_q == IDLE) || (state_q == DONE);
         done_q  <= 1'b0;

         if (out_xfer) begin
            b_valid_q <= 1'b0;
            cnt_q     <= cnt_q + CNT_W'(1);
         end
         // A new result overrides the handoff clear above.
         if (in_xfer) begin
            b_valid_q <= 1'b1;
            b_data_q  <= y_d;
            in_cnt_q  <= in_cnt_q + CNT_W'(1);
            for (int k = 0; k < N_TAPS; k++) begin
               x_q[k] <= x_d[k];
            end
         end

         case (state_q)
            IDLE: begin
               if (start_i) begin
                  len_q    <= len_i;
                  shift_q  <= shift_i;
                  in_cnt_q <= '0;
                  cnt_q    <= '0;
                  idle_q   <= 1'b0;
                  for (int k = 0; k < N_TAPS; k++) begin
                     coef_q[k] <= coeff_i[k*COEFF_W +: COEFF_W];
                     x_q[k]    <= '0;
                  end
                  if (len_i == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (in_xfer && (in_cnt_q + CNT_W'(1) == len_q)) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               // Only one result can be outstanding, so this handoff is the last.
               if (out_xfer) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               idle_q  <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               idle_q  <= 1'b1;
            end
         endcase
      end
   end

   assign b_data_o  = b_data_q;
   assign b_valid_o = b_valid_q;
   assign b_strb_o  = '1;
   assign done_o    = done_q;
   assign idle_o    = idle_q;
   assign ready_o   = ready_q;
   assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_fir_stream_engine.sv
// ----------------------------------------------------------------------------
// tb_fir_stream_engine
//   Directed bench for fir_stream_engine with default parameters
//   (DATA_W=16, COEFF_W=16, N_TAPS=4, CNT_W=32). Inputs change 2 time units
//   after the rising edge; outputs are observed on the falling edge or
//   shortly after the input change.
// ----------------------------------------------------------------------------
module tb_fir_stream_engine;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clear_i;
   logic        start_i;
   logic [31:0] len_i;
   logic [63:0] coeff_i;
   logic [5:0]  shift_i;
   logic [15:0] a_data_i;
   logic        a_valid_i;
   logic        a_ready_o;
   logic [15:0] b_data_o;
   logic        b_valid_o;
   logic        b_ready_i;
   logic [1:0]  b_strb_o;
   logic        done_o;
   logic        idle_o;
   logic        ready_o;
   logic [31:0] cnt_o;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   logic signed [63:0] outq[$];

   fir_stream_engine dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i),
      .start_i   (start_i),
      .len_i     (len_i),
      .coeff_i   (coeff_i),
      .shift_i   (shift_i),
      .a_data_i  (a_data_i),
      .a_valid_i (a_valid_i),
      .a_ready_o (a_ready_o),
      .b_data_o  (b_data_o),
      .b_valid_o (b_valid_o),
      .b_ready_i (b_ready_i),
      .b_strb_o  (b_strb_o),
      .done_o    (done_o),
      .idle_o    (idle_o),
      .ready_o   (ready_o),
      .cnt_o     (cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Record every output handshake and every done pulse.
   always @(negedge clk_i) begin
      if (b_valid_o && b_ready_i) outq.push_back(64'($signed(b_data_o)));
      if (done_o) done_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic start_job(input logic [31:0] len, input logic [63:0] coefs, input logic [5:0] sh);
      tick();
      len_i   = len;
      coeff_i = coefs;
      shift_i = sh;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic send(input string tag, input logic signed [15:0] s);
      int n;
      n = 0;
      a_valid_i = 1'b1;
      a_data_i  = s;
      #1;
      while (!a_ready_o && n < 40) begin
         tick();
         #1;
         n++;
      end
      chk({tag, "_a_ready"}, 64'(a_ready_o), 1);
      tick();
      a_valid_i = 1'b0;
   endtask

   task automatic check_job(input string tag, input int e[$], input int d0);
      chk({tag, "_nout"}, outq.size(), e.size());
      for (int i = 0; i < e.size(); i++) begin
         chk($sformatf("%s_y%0d", tag, i), (i < outq.size()) ? outq[i] : 64'bx, e[i]);
      end
      chk({tag, "_cnt"}, 64'(cnt_o), e.size());
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
   endtask

   initial begin
      logic [63:0] c1234;
      int          e[$];
      int          d0;
      c1234 = {16'd4, 16'd3, 16'd2, 16'd1};

      rst_ni    = 1'b1;
      clear_i   = 1'b0;
      start_i   = 1'b0;
      len_i     = '0;
      coeff_i   = '0;
      shift_i   = '0;
      a_data_i  = '0;
      a_valid_i = 1'b0;
      b_ready_i = 1'b1;

      // Reset values
      #1 rst_ni = 1'b0;
      #2;
      chk("rst_idle",    64'(idle_o),    1);
      chk("rst_done",    64'(done_o),    0);
      chk("rst_ready",   64'(ready_o),   0);
      chk("rst_a_ready", 64'(a_ready_o), 0);
      chk("rst_b_valid", 64'(b_valid_o), 0);
      chk("rst_b_data",  64'(b_data_o),  0);
      chk("rst_strb",    64'(b_strb_o),  3);
      chk("rst_cnt",     64'(cnt_o),     0);
      repeat (2) tick();
      rst_ni = 1'b1;
      repeat (2) tick();
      #1;
      chk("idle_ready", 64'(ready_o), 1);

      // Impulse response
      outq.delete();
      d0 = done_cnt;
      start_job(5, c1234, 0);
      send("imp", 1);
      send("imp", 0);
      send("imp", 0);
      send("imp", 0);
      send("imp", 0);
      repeat (5) tick();
      e = '{1, 2, 3, 4, 0};
      check_job("imp", e, d0);
      chk("imp_idle_after", 64'(idle_o), 1);

      // Positive saturation
      outq.delete();
      d0 = done_cnt;
      start_job(3, {4{16'h7FFF}}, 0);
      for (int i = 0; i < 3; i++) send("satp", 16'sh7FFF);
      repeat (5) tick();
      e = '{32767, 32767, 32767};
      check_job("satp", e, d0);

      // Negative saturation
      outq.delete();
      d0 = done_cnt;
      start_job(3, {4{16'h7FFF}}, 0);
      for (int i = 0; i < 3; i++) send("satn", 16'sh8000);
      repeat (5) tick();
      e = '{-32768, -32768, -32768};
      check_job("satn", e, d0);

      // Arithmetic shift rounds toward minus infinity
      outq.delete();
      d0 = done_cnt;
      start_job(2, {48'd0, 16'd3}, 1);
      send("shf", 5);
      send("shf", -5);
      repeat (5) tick();
      e = '{7, -8};
      check_job("shf", e, d0);

      // Backpressure: stall the output for 4 cycles after the 3rd result
      outq.delete();
      d0 = done_cnt;
      start_job(6, c1234, 0);
      send("bp", 1);
      send("bp", 2);
      send("bp", 3);
      b_ready_i = 1'b0;
      a_valid_i = 1'b1;
      a_data_i  = 16'd4;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bp_stall%0d_a_ready", i), 64'(a_ready_o), 0);
         chk($sformatf("bp_stall%0d_b_valid", i), 64'(b_valid_o), 1);
         chk($sformatf("bp_stall%0d_b_data", i), 64'($signed(b_data_o)), 10);
         chk($sformatf("bp_stall%0d_ready", i), 64'(ready_o), 0);
         tick();
         #1;
      end
      b_ready_i = 1'b1;
      send("bp", 4);
      send("bp", 5);
      send("bp", 6);
      repeat (5) tick();
      e = '{1, 4, 10, 20, 30, 40};
      check_job("bp", e, d0);

      // Zero-length job
      outq.delete();
      d0 = done_cnt;
      start_job(0, c1234, 0);
      #1;
      chk("len0_done_2nd_cycle", 64'(done_o), 1);
      chk("len0_a_ready", 64'(a_ready_o), 0);
      tick();
      #1;
      chk("len0_done_end", 64'(done_o), 0);
      chk("len0_idle", 64'(idle_o), 1);
      chk("len0_cnt", 64'(cnt_o), 0);
      chk("len0_done_pulses", done_cnt - d0, 1);
      chk("len0_nout", outq.size(), 0);

      // Clear after 2 of 8 samples, then a fresh job from zero history
      d0 = done_cnt;
      start_job(8, c1234, 0);
      send("clr", 7);
      send("clr", 8);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      #1;
      chk("clr_idle", 64'(idle_o), 1);
      chk("clr_b_valid", 64'(b_valid_o), 0);
      chk("clr_cnt", 64'(cnt_o), 0);
      chk("clr_a_ready", 64'(a_ready_o), 0);
      repeat (3) tick();
      chk("clr_no_done", done_cnt - d0, 0);
      outq.delete();
      d0 = done_cnt;
      start_job(3, c1234, 0);
      send("clr2", 1);
      send("clr2", 1);
      send("clr2", 1);
      repeat (5) tick();
      e = '{1, 3, 6};
      check_job("clr2", e, d0);

      // Reset mid-job, then a fresh job
      d0 = done_cnt;
      start_job(8, c1234, 0);
      send("rmj", 7);
      send("rmj", 8);
      rst_ni = 1'b0;
      #1;
      chk("rmj_idle", 64'(idle_o), 1);
      chk("rmj_b_valid", 64'(b_valid_o), 0);
      chk("rmj_cnt", 64'(cnt_o), 0);
      chk("rmj_a_ready", 64'(a_ready_o), 0);
      tick();
      rst_ni = 1'b1;
      repeat (3) tick();
      chk("rmj_no_done", done_cnt - d0, 0);
      outq.delete();
      d0 = done_cnt;
      start_job(3, c1234, 0);
      send("rmj2", 1);
      send("rmj2", 1);
      send("rmj2", 1);
      repeat (5) tick();
      e = '{1, 3, 6};
      check_job("rmj2", e, d0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_stream_engine.md
FIR_STREAM_ENGINE -- requirements
Module: fir_stream_engine

Interface
REQ-001 Parameter DATA_W, default 16, sample width (signed, two's complement, multiple of 8).
REQ-002 Parameter COEFF_W, default 16, coefficient width (signed).
REQ-003 Parameter N_TAPS, default 4, filter taps, range 1..32.
REQ-004 Parameter CNT_W, default 32, width of length and count fields.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 clear_i  in  1  synchronous flush of all state.
REQ-008 start_i  in  1  job start pulse.
REQ-009 len_i  in  CNT_W  samples to process in the job.
REQ-010 coeff_i  in  N_TAPS*COEFF_W  coefficients; tap k at bits [k*COEFF_W +: COEFF_W].
REQ-011 shift_i  in  6  arithmetic right shift applied to the accumulator.
REQ-012 a_data_i/a_valid_i/a_ready_o  in/in/out  DATA_W/1/1  input sample stream.
REQ-013 b_data_o/b_valid_o/b_ready_i  out/out/in  DATA_W/1/1  output sample stream.
REQ-014 b_strb_o  out  DATA_W/8  byte strobe, constant all-ones.
REQ-015 done_o, idle_o, ready_o  out  1 each  job status flags.
REQ-016 cnt_o  out  CNT_W  output samples delivered in the current job.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE with start_i=1: latch len_i, coeff_i and shift_i; zero delay line and cnt_o. Go to RUN, or to DONE if len_i=0.
REQ-019 start_i outside IDLE is ignored; latched parameters are stable for the whole job.
REQ-020 a_ready_o = (state==RUN) & (~b_valid_o | b_ready_i); a transfer occurs when a_valid_i & a_ready_o.
REQ-021 On each input transfer, shift the delay line so x[0] = new sample and x[k] = previous x[k-1].
REQ-022 On the same input transfer, compute y = sum over k of coeff[k]*x[k] using the new line contents; pre-job history is zero.
REQ-023 Accumulator is full precision, DATA_W+COEFF_W+clog2(N_TAPS) bits, signed.
REQ-024 Shift y arithmetically right by the latched shift_i, then saturate to the signed DATA_W range.
REQ-025 Result is registered into b_data_o, with b_valid_o=1 on the cycle after the input transfer (latency 1).
REQ-026 b_valid_o holds, and b_data_o stays stable, until b_ready_i=1; simultaneous output handoff and new input transfer in one cycle is allowed (full throughput).
REQ-027 Input counter increments per input transfer. When it reaches the latched length, go to DRAIN; no further inputs are accepted.
REQ-028 DRAIN: on the last output handshake, go to DONE.
REQ-029 DONE lasts exactly one cycle: done_o=1 for that cycle, then return to IDLE.
REQ-030 cnt_o increments on every output handshake (b_valid_o & b_ready_i) and holds its final value until the next start.
REQ-031 idle_o=1 only in IDLE.
REQ-032 ready_o is registered and equals 1 the cycle after the FSM is in IDLE or DONE, otherwise 0.
REQ-033 clear_i=1 in any state: next cycle state=IDLE and b_valid_o=0; delay line, counters and outputs are zeroed. Any pending output is discarded.
REQ-034 clear_i has priority over start_i in the same cycle.

Reset
REQ-035 rst_ni low asynchronously forces state=IDLE and b_valid_o=0, and zeroes b_data_o, cnt_o, counters, delay line and latched parameters.
REQ-036 Reset values: done_o=0, idle_o=1, ready_o=0, a_ready_o=0; b_strb_o is all-ones.
REQ-037 Reset asserted mid-job aborts the job with no done_o pulse; after release the block accepts a new start.

Verification
REQ-038 Impulse: coeffs {1,2,3,4}, shift 0, len 5, inputs 1,0,0,0,0, b_ready_i=1 -> outputs 1,2,3,4,0, cnt_o=5, one done_o pulse.
REQ-039 Saturation: DATA_W=COEFF_W=16, all coeffs 32767, inputs 32767 x3, shift 0 -> outputs 32767; inputs -32768 x3 -> outputs -32768.
REQ-040 Shift/rounding: coeffs {3,0,0,0}, shift 1, inputs 5,-5 -> outputs 7,-8.
REQ-041 Backpressure: b_ready_i low for 4 cycles mid-stream -> b_data_o stable, a_ready_o=0, no sample lost or duplicated; results match the unstalled run.
REQ-042 len_i=0 with start_i -> done_o pulses on the 2nd cycle, no input accepted, cnt_o=0.
REQ-043 Mid-job events: clear_i after 2 of 8 samples -> idle_o=1 next cycle, b_valid_o=0, no done_o. The same check applies to rst_ni low mid-job. A following job of len 3 produces correct outputs from a zero history.
